// File: rtl/spi_memory_master.sv
// SPI mode-0 master for single-byte reads and writes to the board SPI memory.
// Frame: {addr, rw} then one data byte. Defining MISO_SYNC_EN adds a 2-flop miso synchronizer.
module spi_memory_master #(
    parameter int CLK_DIV    = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic                  rw_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  sclk_o,
    output logic                  cs_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    // state   | meaning
    // S_IDLE  | waiting for start, cs high
    // S_SETUP | cs low, first mosi bit presented, sclk low for CLK_DIV
    // S_SHIFT | 16 sclk periods (CLK_DIV high, CLK_DIV low)
    // S_HOLD  | cs still low, sclk low for CLK_DIV
    // S_DONE  | one cycle: cs high, done pulse, rdata loaded on reads
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    localparam int         CMD_BITS   = ADDR_WIDTH + 1;
    localparam int         SHIFT_BITS = CMD_BITS + DATA_WIDTH;
    localparam int         CNT_W      = $clog2(SHIFT_BITS + 1);
    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    state_t                  state_q, state_d;
    logic [7:0]              div_q, div_d;
    logic [CNT_W-1:0]        bit_q, bit_d;
    logic                    sclk_q, sclk_d;
    logic                    rw_q, rw_d;
    logic [SHIFT_BITS-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    miso_s;
    logic                    cs_active;

`ifdef MISO_SYNC_EN
    logic miso_s1_q, miso_s2_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= miso_i;
            miso_s2_q <= miso_s1_q;
        end
    end

    assign miso_s = miso_s2_q;
`else
    assign miso_s = miso_i;
`endif

    // Reads shift out zeros during the data phase.
    assign tx_data = rw_i ? '0 : wdata_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            rw_q    <= 1'b0;
            shift_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            rw_q    <= rw_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        rw_d    = rw_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SETUP;
                    div_d   = DIV_RELOAD;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    rw_d    = rw_i;
                    shift_d = {addr_i, rw_i, tx_data};
                    rx_d    = '0;
                end
            end
            S_SETUP: begin
                if (div_q == 8'd0) begin
                    state_d = S_SHIFT;
                    div_d   = DIV_RELOAD;
                    sclk_d  = 1'b1;
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            S_SHIFT: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    div_d = DIV_RELOAD;
                    if (sclk_q) begin
                        sclk_d  = 1'b0;
                        shift_d = {shift_q[SHIFT_BITS-2:0], 1'b0};
                        bit_d   = bit_q + CNT_W'(1);
                    end else if (bit_q == CNT_W'(SHIFT_BITS)) begin
                        // Last low half-period finished; sclk stays low into HOLD.
                        state_d = S_HOLD;
                    end else begin
                        sclk_d = 1'b1;
                        if (bit_q >= CNT_W'(CMD_BITS)) begin
                            rx_d = {rx_q[DATA_WIDTH-2:0], miso_s};
                        end
                    end
                end
            end
            S_HOLD: begin
                if (div_q == 8'd0) begin
                    state_d = S_DONE;
                    // Loaded one edge early so rdata is already valid while done is high.
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    div_d = div_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cs_active = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign cs_o    = ~cs_active;
    assign sclk_o  = sclk_q;
    assign mosi_o  = cs_active ? shift_q[SHIFT_BITS-1] : 1'b0;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_spi_memory_master.sv
// Directed self-checking bench for spi_memory_master with a mode-0 responder model.
module tb_spi_memory_master;

`ifdef MISO_SYNC_EN
    localparam int CD = 4;
`else
    localparam int CD = 2;
`endif
    localparam int DONE_CYC = 1 + 34 * CD;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy_o, done_o, sclk_o, cs_o, mosi_o;
    logic [7:0] rdata_o;
    logic       miso = 1'b0;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [7:0]  resp_byte = 8'h00;
    logic [15:0] mosi_cap  = 16'h0000;
    int          rise_cnt  = 0;
    int          fall_cnt  = 0;
    int          cs_low_cnt = 0;
    int          done_cnt  = 0;
    logic        sclk_prev = 1'b0;

    always #5 clk = ~clk;

    spi_memory_master #(.CLK_DIV(CD), .ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .start_i   (start),
        .rw_i      (rw),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rdata_o   (rdata_o),
        .sclk_o    (sclk_o),
        .cs_o      (cs_o),
        .mosi_o    (mosi_o),
        .miso_i    (miso)
    );

    // Responder: captures mosi on sclk rises, drives data byte MSB first after falls 8..15.
    always @(posedge clk) begin
        #2;
        if (cs_o) begin
            fall_cnt = 0;
        end else begin
            cs_low_cnt++;
            if (!sclk_prev && sclk_o) begin
                mosi_cap = {mosi_cap[14:0], mosi_o};
                rise_cnt++;
            end
            if (sclk_prev && !sclk_o) begin
                fall_cnt++;
                if (fall_cnt >= 8 && fall_cnt <= 15) miso = resp_byte[15 - fall_cnt];
                else miso = 1'b0;
            end
        end
        if (done_o) done_cnt++;
        sclk_prev = sclk_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input string tag, input logic r, input logic [6:0] a,
                          input logic [7:0] wd, input logic [7:0] resp, input bit hold,
                          input bit stay, input logic [15:0] exp_mosi,
                          input logic [7:0] exp_rd);
        int dcyc, frise, cs0, rise0, done0;
        cs0 = cs_low_cnt; rise0 = rise_cnt; done0 = done_cnt;
        resp_byte = resp; rw = r; addr = a; wdata = wd; start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        chk({tag, "_cs_c1"}, 32'(cs_o), 32'd0);
        chk({tag, "_busy_c1"}, 32'(busy_o), 32'd1);
        addr = ~a; wdata = ~wd; rw = ~r;
        dcyc = 1; frise = 0;
        while (!done_o && dcyc < 100 * CD) begin
            if (sclk_o && frise == 0) frise = dcyc;
            tick();
            dcyc++;
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_done_cyc"}, 32'(dcyc), 32'(DONE_CYC));
        chk({tag, "_first_rise"}, 32'(frise), 32'(1 + CD));
        chk({tag, "_cs_done"}, 32'(cs_o), 32'd1);
        chk({tag, "_rdata"}, 32'(rdata_o), 32'(exp_rd));
        chk({tag, "_mosi"}, 32'(mosi_cap), 32'(exp_mosi));
        chk({tag, "_cs_low_len"}, 32'(cs_low_cnt - cs0), 32'(34 * CD));
        chk({tag, "_rises"}, 32'(rise_cnt - rise0), 32'd16);
        if (!stay) begin
            tick();
            chk({tag, "_busy_after"}, 32'(busy_o), 32'd0);
            chk({tag, "_cs_after"}, 32'(cs_o), 32'd1);
            chk({tag, "_done_after"}, 32'(done_o), 32'd0);
            chk({tag, "_done_pulses"}, 32'(done_cnt - done0), 32'd1);
        end
    endtask

    initial begin
        int n, done_snap;
        reset_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (3) tick();
        chk("rst_cs", 32'(cs_o), 32'd1);
        chk("rst_sclk", 32'(sclk_o), 32'd0);
        chk("rst_mosi", 32'(mosi_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_rdata", 32'(rdata_o), 32'd0);
        reset_n = 1'b1;
        tick();

        do_txn("wr15", 1'b0, 7'h15, 8'hA5, 8'h00, 1'b0, 1'b0, 16'h2AA5, 8'h00);
        do_txn("rd15", 1'b1, 7'h15, 8'h00, 8'h5C, 1'b0, 1'b0, 16'h2B00, 8'h5C);

        // Back-to-back: start in DONE is dropped, start in the following cycle is taken.
        do_txn("b2b_rd", 1'b1, 7'h22, 8'h00, 8'h81, 1'b0, 1'b1, 16'h4500, 8'h81);
        start = 1'b1; rw = 1'b0; addr = 7'h33; wdata = 8'h0F;
        tick();
        chk("b2b_ignored_busy", 32'(busy_o), 32'd0);
        chk("b2b_gap_cs", 32'(cs_o), 32'd1);
        do_txn("b2b_wr", 1'b0, 7'h33, 8'h0F, 8'h00, 1'b0, 1'b0, 16'h660F, 8'h81);

        // start held high for the whole read.
        done_snap = done_cnt;
        do_txn("hold_rd", 1'b1, 7'h7F, 8'h00, 8'h96, 1'b1, 1'b0, 16'hFF00, 8'h96);
        repeat (5) tick();
        chk("hold_idle_busy", 32'(busy_o), 32'd0);
        chk("hold_one_done", 32'(done_cnt - done_snap), 32'd1);

        // Reset during the 5th sclk-high phase of a write.
        done_snap = done_cnt;
        rw = 1'b0; addr = 7'h0A; wdata = 8'h3C; resp_byte = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (n < 1 + 9 * CD) begin
            tick();
            n++;
        end
        chk("midrst_sclk_hi", 32'(sclk_o), 32'd1);
        reset_n = 1'b0;
        tick();
        chk("midrst_cs", 32'(cs_o), 32'd1);
        chk("midrst_sclk", 32'(sclk_o), 32'd0);
        chk("midrst_mosi", 32'(mosi_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_rdata", 32'(rdata_o), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("midrst_no_done", 32'(done_cnt - done_snap), 32'd0);
        do_txn("rd01", 1'b1, 7'h01, 8'h00, 8'hC3, 1'b0, 1'b0, 16'h0300, 8'hC3);

        // All-ones then all-zeros read data.
        do_txn("rdFF", 1'b1, 7'h40, 8'h00, 8'hFF, 1'b0, 1'b0, 16'h8100, 8'hFF);
        do_txn("rd00", 1'b1, 7'h40, 8'h00, 8'h00, 1'b0, 1'b0, 16'h8100, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
